// File: rtl/bmp_sched_pkg.sv
// bmp_sched_pkg: shared command layout, op codes and issue-FSM states for the placer scheduler
package bmp_sched_pkg;
    localparam int CMD_W      = 27;
    localparam int CNT_W      = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int OP_HI  = 26;
    localparam int OP_LO  = 25;
    localparam int IDX_HI = 24;
    localparam int IDX_LO = 19;
    localparam int X_HI   = 18;
    localparam int X_LO   = 9;
    localparam int Y_HI   = 8;
    localparam int Y_LO   = 0;
    typedef enum logic [1:0] {OP_ADD_IMG, OP_REM_IMG, OP_ADD_FNT, OP_ILL} op_t;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP, WAIT} sched_state_t;
endpackage

// File: rtl/bmp_cmd_sched_if.sv
// bmp_cmd_sched_if: requester handshakes, placer command strobes and scheduler status
interface bmp_cmd_sched_if
    import bmp_sched_pkg::*;
    ;
    logic             req0_vld, req0_rdy, req1_vld, req1_rdy;
    logic [CMD_W-1:0] req0_cmd, req1_cmd;
    logic             plc_add_img, plc_rem_img, plc_add_fnt, plc_busy;
    logic [4:0]       plc_image_indx;
    logic [5:0]       plc_fnt_indx;
    logic [9:0]       plc_xloc;
    logic [8:0]       plc_yloc;
    logic [CNT_W-1:0] fifo_cnt;
    logic             sched_busy, err_op;
    modport master (
        output req0_vld, req0_cmd, req1_vld, req1_cmd, plc_busy,
        input  req0_rdy, req1_rdy, plc_add_img, plc_rem_img, plc_add_fnt,
               plc_image_indx, plc_fnt_indx, plc_xloc, plc_yloc, fifo_cnt, sched_busy, err_op
    );
    modport slave (
        input  req0_vld, req0_cmd, req1_vld, req1_cmd, plc_busy,
        output req0_rdy, req1_rdy, plc_add_img, plc_rem_img, plc_add_fnt,
               plc_image_indx, plc_fnt_indx, plc_xloc, plc_yloc, fifo_cnt, sched_busy, err_op
    );
endinterface

// File: rtl/bmp_cmd_sched_fifo.sv
// cmd_fifo: synchronous command FIFO; a pop frees the slot a same-cycle push needs when full
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 27
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + AW'(do_push);
            rp  <= rp + AW'(do_pop);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    // storage needs no reset; occupancy gates every read
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
endmodule

// File: rtl/bmp_cmd_sched.sv
// bmp_cmd_sched: round-robin two requesters into a FIFO and issue one placer command at a time
module bmp_cmd_sched
    import bmp_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = bmp_sched_pkg::FIFO_DEPTH
) (
    input logic              clk,
    input logic              rst_n,
    bmp_cmd_sched_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    sched_state_t     state, state_nx;
    op_t              cur_op;
    logic [CMD_W-1:0] cur_cmd, din, dout;
    logic [CW-1:0]    cnt;
    logic             full, empty, pop, push, g0, g1, last_grant, err_q;
    assign pop   = state == IDLE && !empty;
    assign g0    = bus.req0_vld && (!full || pop) && (!bus.req1_vld || last_grant);
    assign g1    = bus.req1_vld && (!full || pop) && (!bus.req0_vld || !last_grant);
    assign push  = g0 || g1;
    assign din   = g0 ? bus.req0_cmd : bus.req1_cmd;
    assign cur_op = op_t'(cur_cmd[OP_HI:OP_LO]);
    assign bus.req0_rdy       = g0;
    assign bus.req1_rdy       = g1;
    assign bus.plc_image_indx = cur_cmd[IDX_LO+4:IDX_LO];
    assign bus.plc_fnt_indx   = cur_cmd[IDX_HI:IDX_LO];
    assign bus.plc_xloc       = cur_cmd[X_HI:X_LO];
    assign bus.plc_yloc       = cur_cmd[Y_HI:Y_LO];
    assign bus.fifo_cnt       = CNT_W'(cnt);
    assign bus.sched_busy     = !empty || state != IDLE;
    assign bus.err_op         = err_q;
    cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .cnt   (cnt)
    );
    // issue state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    // next state: the GAP cycle masks plc_busy until the placer has reacted to the pulse
    always_comb
        state_nx = state == IDLE  ? (empty ? IDLE : ISSUE) :
                   state == ISSUE ? (cur_op == OP_ILL ? IDLE : GAP) :
                   state == GAP   ? WAIT :
                   (bus.plc_busy ? WAIT : IDLE);
    // single-cycle strobes decoded from the held command
    always_comb begin
        bus.plc_add_img = state == ISSUE && cur_op == OP_ADD_IMG;
        bus.plc_rem_img = state == ISSUE && cur_op == OP_REM_IMG;
        bus.plc_add_fnt = state == ISSUE && cur_op == OP_ADD_FNT;
    end
    // held command, sticky illegal-op flag and round-robin history (1 = req1 granted last)
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cur_cmd    <= '0;
            err_q      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (pop) cur_cmd <= dout;
            if (state == ISSUE && cur_op == OP_ILL) err_q <= 1'b1;
            if (push) last_grant <= g1;
        end
endmodule
